// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared CPU fetch definitions (FSM state encodings, NOP word)
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_t;
  localparam logic [15:0] NOP = 16'h0000;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry skid buffer holding an accepted instruction while decode stalls
module fetch_skid
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic        drain,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_plus_in,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc_plus
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid   <= 1'b0;
      instr   <= NOP;
      pc_plus <= '0;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= instr_in;
      pc_plus <= pc_plus_in;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch FSM driving imem and the IF/ID register with a skid buffer
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_addr,
  output logic        pc_hold,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        flush,
  input  logic        hlt,
  input  logic        id_stall,
  output logic [15:0] IF_ID_instr,
  output logic [15:0] IF_ID_pc_plus,
  output logic        IF_ID_valid
);
  fetch_state_t state, state_n;
  logic [15:0] addr_q, skid_instr, skid_pc_plus, pc_plus;
  logic launch, accept, stall_hold, skid_valid;
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        launch  = !hlt && !flush && !skid_valid;
        state_n = launch ? REQ : IDLE;
      end
      REQ: begin
        accept  = imem_rdy && !flush;
        state_n = imem_rdy ? IDLE : flush ? KILL : REQ;
      end
      KILL:    state_n = imem_rdy ? IDLE : KILL;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= state_n;
      if (launch) addr_q <= pc_addr;
    end
  assign imem_req   = state != IDLE;
  assign imem_addr  = addr_q;
  assign pc_hold    = !accept;
  assign pc_plus    = addr_q + 16'd1;
  assign stall_hold = IF_ID_valid && id_stall;
  fetch_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (accept && stall_hold),
    .clear      (flush),
    .drain      (skid_valid && !stall_hold),
    .instr_in   (imem_data),
    .pc_plus_in (pc_plus),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc_plus    (skid_pc_plus)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      IF_ID_valid   <= 1'b0;
      IF_ID_instr   <= NOP;
      IF_ID_pc_plus <= '0;
    end else if (flush) begin
      IF_ID_valid <= 1'b0;
    end else if (!stall_hold) begin
      IF_ID_valid <= skid_valid || accept;
      if (skid_valid) begin
        IF_ID_instr   <= skid_instr;
        IF_ID_pc_plus <= skid_pc_plus;
      end else if (accept) begin
        IF_ID_instr   <= imem_data;
        IF_ID_pc_plus <= pc_plus;
      end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus checked every cycle against a transaction-level fetch model
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] pc_addr = 16'h0010;
  logic [15:0] imem_data = 16'h0000;
  logic imem_rdy = 1'b0;
  logic flush = 1'b0;
  logic hlt = 1'b0;
  logic id_stall = 1'b0;
  logic pc_hold, imem_req, IF_ID_valid;
  logic [15:0] imem_addr, IF_ID_instr, IF_ID_pc_plus;
  int checks = 0;
  int errors = 0;
  int req_cnt;
  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_addr       (pc_addr),
    .pc_hold       (pc_hold),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdy      (imem_rdy),
    .imem_data     (imem_data),
    .flush         (flush),
    .hlt           (hlt),
    .id_stall      (id_stall),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_pc_plus (IF_ID_pc_plus),
    .IF_ID_valid   (IF_ID_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic in_flight = 1'b0;
  logic squashed = 1'b0;
  logic [15:0] fetch_addr = 16'h0000;
  logic ifid_v = 1'b0;
  logic [15:0] ifid_i = 16'h0000;
  logic [15:0] ifid_p = 16'h0000;
  logic skid_v = 1'b0;
  logic [15:0] skid_i = 16'h0000;
  logic [15:0] skid_p = 16'h0000;
  logic took, had_skid;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight = 1'b0;
      squashed = 1'b0;
      fetch_addr = 16'h0000;
      ifid_v = 1'b0;
      ifid_i = 16'h0000;
      ifid_p = 16'h0000;
      skid_v = 1'b0;
    end else begin
      took = in_flight && !squashed && imem_rdy && !flush;
      had_skid = skid_v;
      if (flush) begin
        ifid_v = 1'b0;
        skid_v = 1'b0;
      end else if (ifid_v && id_stall) begin
        if (took) begin
          skid_v = 1'b1;
          skid_i = imem_data;
          skid_p = fetch_addr + 16'd1;
        end
      end else if (skid_v) begin
        ifid_v = 1'b1;
        ifid_i = skid_i;
        ifid_p = skid_p;
        skid_v = 1'b0;
      end else if (took) begin
        ifid_v = 1'b1;
        ifid_i = imem_data;
        ifid_p = fetch_addr + 16'd1;
      end else begin
        ifid_v = 1'b0;
      end
      if (in_flight) begin
        if (imem_rdy) begin
          in_flight = 1'b0;
          squashed = 1'b0;
        end else if (flush) begin
          squashed = 1'b1;
        end
      end else if (!hlt && !flush && !had_skid) begin
        in_flight = 1'b1;
        fetch_addr = pc_addr;
      end
    end
  end
  always @(negedge clk) begin
    chk("imem_req", {15'b0, imem_req}, {15'b0, in_flight});
    chk("pc_hold", {15'b0, pc_hold}, {15'b0, !(in_flight && !squashed && imem_rdy && !flush)});
    if (in_flight) chk("imem_addr", imem_addr, fetch_addr);
    chk("IF_ID_valid", {15'b0, IF_ID_valid}, {15'b0, ifid_v});
    if (ifid_v) begin
      chk("IF_ID_instr", IF_ID_instr, ifid_i);
      chk("IF_ID_pc_plus", IF_ID_pc_plus, ifid_p);
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {15'b0, imem_req}, 16'h0000);
    chk("rst_hold", {15'b0, pc_hold}, 16'h0001);
    chk("rst_valid", {15'b0, IF_ID_valid}, 16'h0000);
    rst = 1'b0;
    step();
    chk("s1_req", {15'b0, imem_req}, 16'h0001);
    chk("s1_addr", imem_addr, 16'h0010);
    imem_rdy = 1'b1;
    imem_data = 16'hA5A5;
    #1;
    chk("s1_accept_hold", {15'b0, pc_hold}, 16'h0000);
    step();
    imem_rdy = 1'b0;
    hlt = 1'b1;
    #1;
    chk("s1_valid", {15'b0, IF_ID_valid}, 16'h0001);
    chk("s1_instr", IF_ID_instr, 16'hA5A5);
    chk("s1_pc_plus", IF_ID_pc_plus, 16'h0011);
    chk("s1_hold_after", {15'b0, pc_hold}, 16'h0001);
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      req_cnt += int'(imem_req);
    end
    chk("hlt_idle_reqs", req_cnt[15:0], 16'h0000);
    pc_addr = 16'h0020;
    hlt = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("s2_wait_addr", imem_addr, 16'h0020);
      chk("s2_wait_hold", {15'b0, pc_hold}, 16'h0001);
      step();
    end
    imem_rdy = 1'b1;
    imem_data = 16'hBEEF;
    hlt = 1'b1;
    #1;
    chk("s2_accept_hold", {15'b0, pc_hold}, 16'h0000);
    step();
    imem_rdy = 1'b0;
    #1;
    chk("s2_hlt_instr", IF_ID_instr, 16'hBEEF);
    chk("s2_hlt_pc_plus", IF_ID_pc_plus, 16'h0021);
    pc_addr = 16'h0030;
    hlt = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    pc_addr = 16'h0040;
    chk("s3_kill_req", {15'b0, imem_req}, 16'h0001);
    step();
    imem_rdy = 1'b1;
    imem_data = 16'hDEAD;
    #1;
    chk("s3_kill_hold", {15'b0, pc_hold}, 16'h0001);
    step();
    imem_rdy = 1'b0;
    chk("s3_discard_valid", {15'b0, IF_ID_valid}, 16'h0000);
    step();
    chk("s3_redirect_addr", imem_addr, 16'h0040);
    imem_rdy = 1'b1;
    imem_data = 16'h1111;
    step();
    imem_rdy = 1'b0;
    id_stall = 1'b1;
    pc_addr = 16'h0050;
    step();
    imem_rdy = 1'b1;
    imem_data = 16'h1234;
    step();
    imem_rdy = 1'b0;
    step();
    chk("s4_no_launch", {15'b0, imem_req}, 16'h0000);
    chk("s4_stall_instr", IF_ID_instr, 16'h1111);
    id_stall = 1'b0;
    step();
    hlt = 1'b1;
    chk("s4_skid_instr", IF_ID_instr, 16'h1234);
    chk("s4_skid_pc_plus", IF_ID_pc_plus, 16'h0051);
    chk("s4_drain_no_launch", {15'b0, imem_req}, 16'h0000);
    step();
    pc_addr = 16'hFFFF;
    hlt = 1'b0;
    step();
    imem_rdy = 1'b1;
    imem_data = 16'h7777;
    hlt = 1'b1;
    step();
    imem_rdy = 1'b0;
    hlt = 1'b0;
    chk("s5_wrap_pc_plus", IF_ID_pc_plus, 16'h0000);
    pc_addr = 16'h0060;
    step();
    rst = 1'b1;
    #1;
    chk("s5_rst_req", {15'b0, imem_req}, 16'h0000);
    chk("s5_rst_hold", {15'b0, pc_hold}, 16'h0001);
    imem_rdy = 1'b1;
    imem_data = 16'h9999;
    hlt = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("s5_late_rdy_valid", {15'b0, IF_ID_valid}, 16'h0000);
    chk("s5_late_rdy_req", {15'b0, imem_req}, 16'h0000);
    imem_rdy = 1'b0;
    hlt = 1'b0;
    step();
    chk("s5_relaunch_addr", imem_addr, 16'h0060);
    imem_rdy = 1'b1;
    imem_data = 16'h4242;
    step();
    imem_rdy = 1'b0;
    hlt = 1'b1;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
